bip_instruction_decoder: RTL

//   Control/decode stage of the BIP CPU, directly downstream of Program_Counter + program memory.

---
 rtl/bip_pkg.sv | 37 +++
 rtl/bip_cycle_counter.sv | 30 +++
 rtl/bip_instruction_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP CPU control path: field widths, opcode
// encodings, datapath select/ALU encodings and the decoder FSM state codes.
package bip_pkg;

    localparam int INSTR_W   = 16;
    localparam int OPCODE_W  = 5;
    localparam int OPERAND_W = 11;
    localparam int CNT_W     = 32;

    // Opcode field encodings, instruction[15:11]; 01000..11111 are NOPs.
    localparam logic [OPCODE_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SUBI = 5'b00111;

    // Accumulator input mux selects.
    localparam logic [1:0] SEL_A_RAM  = 2'b00;
    localparam logic [1:0] SEL_A_OPND = 2'b01;
    localparam logic [1:0] SEL_A_ALU  = 2'b10;

    // ALU operation encodings.
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Run state of the CPU; 2'b11 is unused and recovers to boot.
    typedef enum logic [1:0] {
        S_BOOT    = 2'b00,
        S_EXEC    = 2'b01,
        S_HALT    = 2'b10,
        S_UNUSED  = 2'b11
    } state_t;

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating executed-cycle counter for the BIP decoder.
// Only compiled when BIP_CYCLE_COUNT_EN is defined; the decoder instantiates
// it under the same macro, so the default build carries no counter at all.
`ifdef BIP_CYCLE_COUNT_EN
module bip_cycle_counter
    import bip_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count enabled cycles, hold when disabled, stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`endif

// File: rtl/bip_instruction_decoder.sv
// BIP CPU control/decode stage: run-state FSM (boot, execute, halt) plus
// combinational opcode decode into PC, accumulator, ALU and data-RAM strobes.
// Optional feature macro: BIP_CYCLE_COUNT_EN adds the cycle_count output,
// a saturating count of cycles spent in boot and execute.
module bip_instruction_decoder
    import bip_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instruction,
    output logic                 wr_pc,
    output logic [1:0]           sel_a,
    output logic                 sel_b,
    output logic                 alu_op,
    output logic                 wr_acc,
    output logic                 rd_ram,
    output logic                 wr_ram,
    output logic [OPERAND_W-1:0] operand,
    output logic                 halted
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_count
`endif
);

    state_t                r_state;
    state_t                w_next_state;
    logic [OPCODE_W-1:0]   w_opcode;

    assign w_opcode = instruction[INSTR_W-1:OPERAND_W];

    // State register; reset from any state returns to boot.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and opcode decode into datapath strobes.
    always_comb begin
        // NOTE: defaults first, so any path not assigning an output cannot infer a latch.
        w_next_state = S_BOOT;
        wr_pc        = 1'b0;
        sel_a        = SEL_A_RAM;
        sel_b        = 1'b0;
        alu_op       = ALU_ADD;
        wr_acc       = 1'b0;
        rd_ram       = 1'b0;
        wr_ram       = 1'b0;
        operand      = '0;
        halted       = 1'b0;

        case (r_state)
            // Boot spends one cycle hiding program-memory read latency.
            S_BOOT: begin
                w_next_state = S_EXEC;
            end

            S_EXEC: begin
                w_next_state = S_EXEC;
                operand      = instruction[OPERAND_W-1:0];
                wr_pc        = 1'b1;
                case (w_opcode)
                    OP_HLT: begin
                        wr_pc        = 1'b0;
                        w_next_state = S_HALT;
                    end
                    OP_STO: begin
                        wr_ram = 1'b1;
                    end
                    OP_LD: begin
                        rd_ram = 1'b1;
                        sel_a  = SEL_A_RAM;
                        wr_acc = 1'b1;
                    end
                    OP_LDI: begin
                        sel_a  = SEL_A_OPND;
                        wr_acc = 1'b1;
                    end
                    OP_ADD: begin
                        rd_ram = 1'b1;
                        sel_a  = SEL_A_ALU;
                        sel_b  = 1'b1;
                        alu_op = ALU_ADD;
                        wr_acc = 1'b1;
                    end
                    OP_ADDI: begin
                        sel_a  = SEL_A_ALU;
                        sel_b  = 1'b0;
                        alu_op = ALU_ADD;
                        wr_acc = 1'b1;
                    end
                    OP_SUB: begin
                        rd_ram = 1'b1;
                        sel_a  = SEL_A_ALU;
                        sel_b  = 1'b1;
                        alu_op = ALU_SUB;
                        wr_acc = 1'b1;
                    end
                    OP_SUBI: begin
                        sel_a  = SEL_A_ALU;
                        sel_b  = 1'b0;
                        alu_op = ALU_SUB;
                        wr_acc = 1'b1;
                    end
                    default: begin
                        // Remaining opcodes are NOPs: only the PC advances.
                    end
                endcase
            end

            // Halt is sticky; the instruction input is ignored here.
            S_HALT: begin
                w_next_state = S_HALT;
                halted       = 1'b1;
            end

            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic w_count_en;

    assign w_count_en = (r_state == S_BOOT) || (r_state == S_EXEC);

    bip_cycle_counter #(
        .W (CNT_W)
    ) u_cycle_counter (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_count_en),
        .o_count (cycle_count)
    );
`endif

endmodule
